sc_fifo_flagged: RTL and testbench

//  Parametrised single-clock FIFO: successor of the fixed 128x64 count FIFO.
//  - Full-width occupancy count: values 0..DEPTH, no truncation at full.
//  - Almost-full / almost-empty watermarks for flow control.
//  - Sticky overflow / underflow error flags.

---
 rtl/sc_fifo_flagged.sv | 112 +++++++++++
 tb/tb_sc_fifo_flagged.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sc_fifo_flagged.sv
// sc_fifo_flagged: parametrised single-clock FIFO with full-width occupancy
// count, almost-full/almost-empty watermarks and sticky overflow/underflow.
// Optional feature macro: SCFIFO_FWFT_EN selects first-word fall-through
// read data; left undefined, read data is a register loaded on each pop.
module sc_fifo_flagged #(
  parameter int DATA_WIDTH    = 128,
  parameter int DEPTH         = 64,
  parameter int AFULL_THRESH  = 56,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic [DATA_WIDTH-1:0]   iPushData,
  input  logic                    iPushEnable,
  output logic                    oIsFull,
  output logic                    oIsAlmostFull,
  output logic [DATA_WIDTH-1:0]   oPopData,
  input  logic                    iPopEnable,
  output logic                    oIsEmpty,
  output logic                    oIsAlmostEmpty,
  output logic [$clog2(DEPTH):0]  oDataCount,
  output logic                    oOverflow,
  output logic                    oUnderflow,
  input  logic                    iClearError
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_nxt;
  logic                  push_acc;
  logic                  pop_acc;

  // Acceptance is judged on the registered (pre-edge) flags only, so a pop
  // never frees room for a push in the same cycle and vice versa.
  always_comb begin
    push_acc  = iPushEnable & ~oIsFull;
    pop_acc   = iPopEnable  & ~oIsEmpty;
    count_nxt = oDataCount + CW'(push_acc) - CW'(pop_acc);
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge iClock) begin
    if (push_acc) begin
      mem[wr_ptr] <= iPushData;
    end
  end

  // Pointers, occupancy and status flags, all registered from the next count.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      oDataCount     <= '0;
      oIsEmpty       <= 1'b1;
      oIsAlmostEmpty <= 1'b1;
      oIsFull        <= 1'b0;
      oIsAlmostFull  <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      oDataCount     <= count_nxt;
      oIsEmpty       <= (count_nxt == '0);
      oIsAlmostEmpty <= (count_nxt <= CW'(AEMPTY_THRESH));
      oIsFull        <= (count_nxt == CW'(DEPTH));
      oIsAlmostFull  <= (count_nxt >= CW'(AFULL_THRESH));
    end
  end

  // Sticky error flags; a fresh error outranks a clear in the same cycle.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      oOverflow  <= 1'b0;
      oUnderflow <= 1'b0;
    end else begin
      if (iPushEnable && oIsFull) begin
        oOverflow <= 1'b1;
      end else if (iClearError) begin
        oOverflow <= 1'b0;
      end
      if (iPopEnable && oIsEmpty) begin
        oUnderflow <= 1'b1;
      end else if (iClearError) begin
        oUnderflow <= 1'b0;
      end
    end
  end

`ifdef SCFIFO_FWFT_EN
  // Head of queue presented combinationally; zero while empty.
  always_comb begin
    oPopData = oIsEmpty ? '0 : mem[rd_ptr];
  end
`else
  // Read register loaded on each accepted pop and held otherwise.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      oPopData <= '0;
    end else if (pop_acc) begin
      oPopData <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sc_fifo_flagged.sv
// tb_sc_fifo_flagged: directed and random-sequence bench for sc_fifo_flagged
// at the default geometry (128 bits x 64 entries, watermarks 56 / 8).
module tb_sc_fifo_flagged;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] push_data = '0;
  logic         push_en = 1'b0;
  logic         full;
  logic         afull;
  logic [127:0] pop_data;
  logic         pop_en = 1'b0;
  logic         empty;
  logic         aempty;
  logic [6:0]   count;
  logic         ovf;
  logic         unf;
  logic         clr = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [127:0] q [$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;
  logic [127:0] m_pop = '0;

  sc_fifo_flagged dut (
    .iClock        (clk),
    .iReset        (rst),
    .iPushData     (push_data),
    .iPushEnable   (push_en),
    .oIsFull       (full),
    .oIsAlmostFull (afull),
    .oPopData      (pop_data),
    .iPopEnable    (pop_en),
    .oIsEmpty      (empty),
    .oIsAlmostEmpty(aempty),
    .oDataCount    (count),
    .oOverflow     (ovf),
    .oUnderflow    (unf),
    .iClearError   (clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_pop();
`ifdef SCFIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : 128'd0;
`else
    return m_pop;
`endif
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".count"},  {121'd0, count}, 128'(q.size()));
    check({tag, ".full"},   full,   q.size() == 64);
    check({tag, ".afull"},  afull,  q.size() >= 56);
    check({tag, ".empty"},  empty,  q.size() == 0);
    check({tag, ".aempty"}, aempty, q.size() <= 8);
    check({tag, ".ovf"},    ovf,    m_ovf);
    check({tag, ".unf"},    unf,    m_unf);
    check({tag, ".data"},   pop_data, exp_pop());
  endtask

  // One clock with the given inputs; the model advances alongside.
  task automatic step(input string tag, input logic pu, input logic [127:0] d,
                      input logic po, input logic cl);
    logic pre_full, pre_empty;
    push_en = pu; push_data = d; pop_en = po; clr = cl;
    pre_full  = (q.size() == 64);
    pre_empty = (q.size() == 0);
    if (po && !pre_empty) m_pop = q.pop_front();
    if (pu && !pre_full) q.push_back(d);
    if (pu && pre_full) m_ovf = 1'b1; else if (cl) m_ovf = 1'b0;
    if (po && pre_empty) m_unf = 1'b1; else if (cl) m_unf = 1'b0;
    @(posedge clk); #1;
    push_en = 1'b0; pop_en = 1'b0; clr = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; push_en = 1'b0; pop_en = 1'b0; clr = 1'b0;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_pop = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] a;
    // 1: reset state and fill
    do_reset();
    check("rst.count", {121'd0, count}, 128'd0);
    check("rst.empty", empty, 1'b1);
    check("rst.aempty", aempty, 1'b1);
    check("rst.full", full, 1'b0);
    check("rst.afull", afull, 1'b0);
    check("rst.data", pop_data, 128'd0);
    check("rst.ovf", ovf, 1'b0);
    check("rst.unf", unf, 1'b0);
    for (int i = 0; i < 64; i++) begin
      step("fill", 1'b1, 128'(i), 1'b0, 1'b0);
      if (i == 8)  check("t1.aempty9", aempty, 1'b0);
      if (i == 54) check("t1.afull55", afull, 1'b0);
      if (i == 55) check("t1.afull56", afull, 1'b1);
    end
    check("t1.count64", {121'd0, count}, 128'd64);
    check("t1.full", full, 1'b1);

    // 2: push+pop while full
    step("t2", 1'b1, 128'hDEAD, 1'b1, 1'b0);
    check("t2.count63", {121'd0, count}, 128'd63);
    check("t2.ovf", ovf, 1'b1);
`ifdef SCFIFO_FWFT_EN
    check("t2.data", pop_data, 128'd1);
`else
    check("t2.data", pop_data, 128'd0);
`endif

    // 3: drain, underflow, clear, clear+pop
    for (int i = 0; i < 63; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    step("t3.pop", 1'b0, '0, 1'b1, 1'b0);
    check("t3.unf", unf, 1'b1);
    check("t3.count0", {121'd0, count}, 128'd0);
    step("t3.clr", 1'b0, '0, 1'b0, 1'b1);
    check("t3.unf_clr", unf, 1'b0);
    check("t3.ovf_clr", ovf, 1'b0);
    step("t3.clrpop", 1'b0, '0, 1'b1, 1'b1);
    check("t3.unf_win", unf, 1'b1);

    // 4: random traffic with pointer wrap
    for (int i = 0; i < 200; i++) begin
      step("rnd", $urandom_range(0, 99) < 60, {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5);
    end

    // 5: read latency
    do_reset();
    a = 128'hA5A5_0000_1234_5678_9ABC_DEF0_0F0F_F0F0;
    step("t5.push", 1'b1, a, 1'b0, 1'b0);
`ifdef SCFIFO_FWFT_EN
    check("t5.fwft", pop_data, a);
`else
    check("t5.before", pop_data, 128'd0);
    step("t5.pop", 1'b0, '0, 1'b1, 1'b0);
    check("t5.std", pop_data, a);
`endif

    // 6: asynchronous reset mid-operation
    do_reset();
    step("t6.unf", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 31; i++) step("t6.push", 1'b1, 128'(i + 100), 1'b0, 1'b0);
    step("t6.pop", 1'b0, '0, 1'b1, 1'b0);
    check("t6.count30", {121'd0, count}, 128'd30);
    #2 rst = 1'b1;
    #1;
    check("t6.count", {121'd0, count}, 128'd0);
    check("t6.empty", empty, 1'b1);
    check("t6.ovf", ovf, 1'b0);
    check("t6.unf", unf, 1'b0);
    check("t6.data", pop_data, 128'd0);
    do_reset();
    check_all("t6.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
